// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS word registers with byte strobes,
// read-only status slots, SLVERR on bad targets and per-register write pulses.
module axi_lite_regbank #(
    parameter int                               ADDR_WIDTH = 32,
    parameter int                               DATA_WIDTH = 32,
    parameter int                               NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]              RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VAL  = '0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [ADDR_WIDTH-1:0]           s_awaddr_i,
    input  logic                            s_awvalid_i,
    output logic                            s_awready_o,
    input  logic [DATA_WIDTH-1:0]           s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]         s_wstrb_i,
    input  logic                            s_wvalid_i,
    output logic                            s_wready_o,
    output logic [1:0]                      s_bresp_o,
    output logic                            s_bvalid_o,
    input  logic                            s_bready_i,
    input  logic [ADDR_WIDTH-1:0]           s_araddr_i,
    input  logic                            s_arvalid_i,
    output logic                            s_arready_o,
    output logic [DATA_WIDTH-1:0]           s_rdata_o,
    output logic [1:0]                      s_rresp_o,
    output logic                            s_rvalid_o,
    input  logic                            s_rready_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]  status_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0]  reg_q_o,
    output logic [NUM_REGS-1:0]             wr_pulse_o
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    w_state_t                w_state_r, w_state_nxt_s;
    r_state_t                r_state_r, r_state_nxt_s;
    logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];
    logic                    awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic [1:0]              bresp_r, rresp_r;
    logic [ADDR_WIDTH-1:0]   awaddr_r;
    logic [DATA_WIDTH-1:0]   wdata_r, rdata_r;
    logic [STRB_W-1:0]       wstrb_r;
    logic [NUM_REGS-1:0]     wr_pulse_r;

    logic                    aw_hs_s, w_hs_s, have_aw_s, have_w_s, commit_s, b_hs_s;
    logic                    ar_hs_s, r_hs_s, wr_ok_s, rd_ok_s;
    logic [ADDR_WIDTH-1:0]   wr_addr_s;
    logic [DATA_WIDTH-1:0]   wr_data_s, rd_data_s;
    logic [STRB_W-1:0]       wr_strb_s;
    logic [NUM_REGS-1:0]     wr_hit_s, rd_hit_s;

    // Write-side decode: a channel not yet held is taken straight from the bus so AW+W can commit in one cycle
    always_comb begin
        aw_hs_s   = s_awvalid_i & awready_r;
        w_hs_s    = s_wvalid_i & wready_r;
        have_aw_s = ~awready_r | s_awvalid_i;
        have_w_s  = ~wready_r | s_wvalid_i;
        wr_addr_s = awready_r ? s_awaddr_i : awaddr_r;
        wr_data_s = wready_r ? s_wdata_i : wdata_r;
        wr_strb_s = wready_r ? s_wstrb_i : wstrb_r;
        commit_s  = (w_state_r == W_IDLE) & have_aw_s & have_w_s;
        b_hs_s    = (w_state_r == W_RESP) & bvalid_r & s_bready_i;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit_s[i] = ((wr_addr_s >> OFF_W) == ADDR_WIDTH'(i));
        end
        wr_ok_s = |(wr_hit_s & ~RO_MASK);
    end

    // Read-side decode; RO slots return the live status word sampled at the AR handshake
    always_comb begin
        ar_hs_s   = (r_state_r == R_IDLE) & s_arvalid_i & arready_r;
        r_hs_s    = (r_state_r == R_DATA) & rvalid_r & s_rready_i;
        rd_data_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_hit_s[i] = ((s_araddr_i >> OFF_W) == ADDR_WIDTH'(i));
            rd_data_s   = rd_data_s | ({DATA_WIDTH{rd_hit_s[i]}} &
                          (RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_r[i]));
        end
        rd_ok_s = |rd_hit_s;
    end

    // Next-state logic for both channel FSMs
    always_comb begin
        w_state_nxt_s = w_state_r;
        r_state_nxt_s = r_state_r;
        case (w_state_r)
            W_IDLE:  w_state_nxt_s = commit_s ? W_RESP : W_IDLE;
            W_RESP:  w_state_nxt_s = b_hs_s ? W_IDLE : W_RESP;
            default: w_state_nxt_s = W_IDLE;
        endcase
        case (r_state_r)
            R_IDLE:  r_state_nxt_s = ar_hs_s ? R_DATA : R_IDLE;
            R_DATA:  r_state_nxt_s = r_hs_s ? R_IDLE : R_DATA;
            default: r_state_nxt_s = R_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_r <= W_IDLE;
            r_state_r <= R_IDLE;
        end else begin
            w_state_r <= w_state_nxt_s;
            r_state_r <= r_state_nxt_s;
        end
    end

    // Write channel handshakes, response and write pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
            awaddr_r   <= '0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            bvalid_r   <= 1'b0;
            bresp_r    <= 2'b00;
            wr_pulse_r <= '0;
        end else begin
            wr_pulse_r <= '0;
            if (aw_hs_s) begin
                awaddr_r  <= s_awaddr_i;
                awready_r <= 1'b0;
            end
            if (w_hs_s) begin
                wdata_r  <= s_wdata_i;
                wstrb_r  <= s_wstrb_i;
                wready_r <= 1'b0;
            end
            if (commit_s) begin
                bvalid_r   <= 1'b1;
                bresp_r    <= wr_ok_s ? 2'b00 : 2'b10;
                wr_pulse_r <= wr_hit_s & ~RO_MASK;
            end else if (b_hs_s) begin
                bvalid_r  <= 1'b0;
                bresp_r   <= 2'b00;
                awready_r <= 1'b1;
                wready_r  <= 1'b1;
            end
        end
    end

    // Register storage with byte-strobe merge; RO slots never take writes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (commit_s && wr_hit_s[i] && !RO_MASK[i] && wr_strb_s[b]) begin
                        regs_r[i][b*8 +: 8] <= wr_data_s[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read channel: data is captured at the AR handshake, so a coincident commit is not visible
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            rresp_r   <= 2'b00;
        end else if (ar_hs_s) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rdata_r   <= rd_data_s;
            rresp_r   <= rd_ok_s ? 2'b00 : 2'b10;
        end else if (r_hs_s) begin
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            rresp_r   <= 2'b00;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
        assign reg_q_o[g*DATA_WIDTH +: DATA_WIDTH] =
            RO_MASK[g] ? status_i[g*DATA_WIDTH +: DATA_WIDTH] : regs_r[g];
    end

    assign s_awready_o = awready_r;
    assign s_wready_o  = wready_r;
    assign s_bvalid_o  = bvalid_r;
    assign s_bresp_o   = bresp_r;
    assign s_arready_o = arready_r;
    assign s_rvalid_o  = rvalid_r;
    assign s_rdata_o   = rdata_r;
    assign s_rresp_o   = rresp_r;
    assign wr_pulse_o  = wr_pulse_r;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank: 8 x 32-bit registers, reg 7 read-only,
// reg 1 with a nonzero reset value.
module tb_axi_lite_regbank;
    localparam logic [7:0]   RO_MASK   = 8'b1000_0000;
    localparam logic [255:0] RESET_VAL = {192'h0, 32'h0000_1111, 32'h0000_0000};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  awaddr = 32'h0, wdata = 32'h0, araddr = 32'h0;
    logic [3:0]   wstrb = 4'h0;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [255:0] status = {32'hCAFE_F00D, 96'h0, 32'h1234_5678, 96'h0};
    logic [255:0] reg_q;
    logic [7:0]   wr_pulse;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0]  resp;
    logic [7:0]  pulse;
    logic [31:0] data;

    axi_lite_regbank #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8),
        .RO_MASK(RO_MASK), .RESET_VAL(RESET_VAL)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_awaddr_i(awaddr), .s_awvalid_i(awvalid), .s_awready_o(awready),
        .s_wdata_i(wdata), .s_wstrb_i(wstrb), .s_wvalid_i(wvalid), .s_wready_o(wready),
        .s_bresp_o(bresp), .s_bvalid_o(bvalid), .s_bready_i(bready),
        .s_araddr_i(araddr), .s_arvalid_i(arvalid), .s_arready_o(arready),
        .s_rdata_o(rdata), .s_rresp_o(rresp), .s_rvalid_o(rvalid), .s_rready_i(rready),
        .status_i(status), .reg_q_o(reg_q), .wr_pulse_o(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write with bready high; returns bresp and the pulse vector seen with the first bvalid cycle
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r, output logic [7:0] p);
        int  n;
        logic aw_pend, w_pend, aw_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_pend = 1'b1; w_pend = 1'b1; n = 0;
        while ((aw_pend || w_pend) && n < 20) begin
            aw_hs = aw_pend && awready;
            w_hs  = w_pend && wready;
            tick();
            if (aw_hs) begin aw_pend = 1'b0; awvalid = 1'b0; end
            if (w_hs)  begin w_pend  = 1'b0; wvalid  = 1'b0; end
            n++;
        end
        while (!bvalid && n < 20) begin tick(); n++; end
        check("write_bvalid", bvalid, 1'b1);
        r = bresp;
        p = wr_pulse;
        tick();
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        while (!rvalid && n < 20) begin tick(); n++; end
        check("read_rvalid", rvalid, 1'b1);
        d = rdata;
        r = rresp;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_awready", awready, 1'b1);
        check("rst_wready", wready, 1'b1);
        check("rst_arready", arready, 1'b1);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_pulse", wr_pulse, 8'h00);
        check("rst_reg1", reg_q[1*32 +: 32], 32'h0000_1111);
        check("rst_reg2", reg_q[2*32 +: 32], 32'h0);

        // Full-word write and read-back
        do_write(32'h08, 32'hDEAD_BEEF, 4'hF, resp, pulse);
        check("w1_bresp", resp, 2'b00);
        check("w1_pulse", pulse, 8'h04);
        check("w1_pulse_gone", wr_pulse, 8'h00);
        do_read(32'h08, data, resp);
        check("r1_data", data, 32'hDEAD_BEEF);
        check("r1_rresp", resp, 2'b00);

        // Partial strobes merge bytes 0 and 2
        do_write(32'h08, 32'h1122_3344, 4'b0101, resp, pulse);
        check("w2_bresp", resp, 2'b00);
        check("w2_reg2", reg_q[2*32 +: 32], 32'hDE22_BE44);
        do_read(32'h08, data, resp);
        check("r2_data", data, 32'hDE22_BE44);

        // W three cycles ahead of AW
        wdata = 32'h0000_00AA; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        tick();
        wvalid = 1'b0;
        check("wfirst_wready", wready, 1'b0);
        check("wfirst_awready", awready, 1'b1);
        check("wfirst_bvalid", bvalid, 1'b0);
        repeat (2) begin
            tick();
            check("wwait_bvalid", bvalid, 1'b0);
            check("wwait_wready", wready, 1'b0);
        end
        awaddr = 32'h0C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wlate_bvalid", bvalid, 1'b1);
        check("wlate_bresp", bresp, 2'b00);
        check("wlate_pulse", wr_pulse, 8'h08);
        check("wlate_awready", awready, 1'b0);
        check("wlate_wready", wready, 1'b0);
        check("wlate_reg3", reg_q[3*32 +: 32], 32'h0000_00AA);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("wlate_bdone", bvalid, 1'b0);
        check("wlate_awready_back", awready, 1'b1);
        check("wlate_wready_back", wready, 1'b1);
        check("wlate_pulse_gone", wr_pulse, 8'h00);
        do_read(32'h0F, data, resp);
        check("r3_lowbits_ignored", data, 32'h0000_00AA);

        // Out-of-range, read-only and zero-strobe targets
        do_write(32'h20, 32'hFFFF_FFFF, 4'hF, resp, pulse);
        check("oor_w_bresp", resp, 2'b10);
        check("oor_w_pulse", pulse, 8'h00);
        check("oor_w_regs", reg_q, {32'hCAFE_F00D, 96'h0, 32'h0000_00AA, 32'hDE22_BE44,
                                    32'h0000_1111, 32'h0});
        do_read(32'h20, data, resp);
        check("oor_r_data", data, 32'h0);
        check("oor_r_rresp", resp, 2'b10);
        do_write(32'h1C, 32'h0000_0001, 4'hF, resp, pulse);
        check("ro_w_bresp", resp, 2'b10);
        check("ro_w_pulse", pulse, 8'h00);
        do_read(32'h1C, data, resp);
        check("ro_r_data", data, 32'hCAFE_F00D);
        check("ro_r_rresp", resp, 2'b00);
        check("rw_slot_not_status", reg_q[3*32 +: 32], 32'h0000_00AA);
        do_write(32'h10, 32'hFFFF_FFFF, 4'h0, resp, pulse);
        check("nostrb_bresp", resp, 2'b00);
        check("nostrb_pulse", pulse, 8'h10);
        check("nostrb_reg4", reg_q[4*32 +: 32], 32'h0);

        // B backpressure with an SLVERR payload
        awaddr = 32'h24; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (5) begin
            check("bhold_bvalid", bvalid, 1'b1);
            check("bhold_bresp", bresp, 2'b10);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bhold_done", bvalid, 1'b0);

        // R backpressure
        araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        check("rhold_arready", arready, 1'b0);
        repeat (5) begin
            check("rhold_rvalid", rvalid, 1'b1);
            check("rhold_rdata", rdata, 32'hDE22_BE44);
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rhold_done", rvalid, 1'b0);
        check("rhold_arready_back", arready, 1'b1);

        // AR handshake in the commit cycle returns the old value
        awaddr = 32'h08; wdata = 32'h0BAD_F00D; wstrb = 4'hF; araddr = 32'h08;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_rdata_old", rdata, 32'hDE22_BE44);
        check("same_bvalid", bvalid, 1'b1);
        check("same_reg2_new", reg_q[2*32 +: 32], 32'h0BAD_F00D);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;

        // Reset between AW and W
        awaddr = 32'h18; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("mid_awready", awready, 1'b0);
        rst = 1'b1;
        #2;
        check("mid_rst_awready", awready, 1'b1);
        check("mid_rst_wready", wready, 1'b1);
        check("mid_rst_bvalid", bvalid, 1'b0);
        check("mid_rst_reg6", reg_q[6*32 +: 32], 32'h0);
        check("mid_rst_reg2", reg_q[2*32 +: 32], 32'h0);
        check("mid_rst_reg1", reg_q[1*32 +: 32], 32'h0000_1111);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_bvalid", bvalid, 1'b0);
        check("post_rst_pulse", wr_pulse, 8'h00);
        do_write(32'h18, 32'h0000_0066, 4'hF, resp, pulse);
        check("post_rst_bresp", resp, 2'b00);
        check("post_rst_wpulse", pulse, 8'h40);
        do_read(32'h18, data, resp);
        check("post_rst_rdata", data, 32'h0000_0066);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
